// File: rtl/cache_mem_arbiter_if.sv
// One memory-port bundle: line request, write beat, ready and return beat.
// The arbiter's cache-facing ports are slaves; its DRAM-facing port is a master.
interface cache_mem_arbiter_if;
  logic [31:0] addr;
  logic        read;
  logic        write;
  logic [63:0] wdata;
  logic        ready;
  logic [31:0] raddr;
  logic [63:0] rdata;
  logic        rvalid;

  modport master (
    output addr, read, write, wdata,
    input  ready, raddr, rdata, rvalid
  );

  modport slave (
    input  addr, read, write, wdata,
    output ready, raddr, rdata, rvalid
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares the DRAM burst port between the icache and dcache miss FSMs and steers
// in-order read returns back to whichever cache issued each read.
module cache_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int BEATS           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  cache_mem_arbiter_if.slave         ic,
  cache_mem_arbiter_if.slave         dc,
  cache_mem_arbiter_if.master        mem
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTSTANDING - 1);
  localparam logic [PW:0]   CNT_FULL  = (PW+1)'(MAX_OUTSTANDING);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [0:0]    ARB       = 1'b0;
  localparam logic [0:0]    WBURST    = 1'b1;
  localparam logic          ID_I      = 1'b0;
  localparam logic          ID_D      = 1'b1;

  logic [0:0]                 state;
  logic                       prio;
  logic [BW-1:0]              wbeat;
  logic [BW-1:0]              rbeat;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [PW:0]                count;
  logic [MAX_OUTSTANDING-1:0] id_fifo;

  logic i_req, d_req, fifo_full, fifo_empty;
  logic i_acc, d_rd_acc, d_wr_acc, push, pop, ret_beat, head_id;
  logic unused_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign i_req      = ic.read;
  assign d_req      = dc.read | dc.write;
  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);

  // A full ID FIFO only holds back reads; write beats never need a slot.
  always_comb begin
    ic.ready = 1'b0;
    dc.ready = 1'b0;
    if (!rst) begin
      if (state == WBURST) begin
        dc.ready = mem.ready;
      end else begin
        ic.ready = mem.ready && !fifo_full && (!d_req || prio == ID_I);
        dc.ready = mem.ready && (dc.write || !fifo_full) && (!i_req || prio == ID_D);
      end
    end
  end

  assign i_acc    = ic.ready & ic.read;
  assign d_wr_acc = dc.ready & dc.write;
  assign d_rd_acc = dc.ready & dc.read & ~dc.write & (state == ARB);

  assign mem.read  = i_acc | d_rd_acc;
  assign mem.write = d_wr_acc;
  assign mem.addr  = i_acc ? ic.addr : dc.addr;
  assign mem.wdata = dc.wdata;

  // Returns come back in issue order, so the FIFO head names the owner of each beat.
  assign head_id   = id_fifo[rd_ptr];
  assign ret_beat  = mem.rvalid & ~fifo_empty & ~rst;
  assign ic.rvalid = ret_beat & (head_id == ID_I);
  assign dc.rvalid = ret_beat & (head_id == ID_D);
  assign ic.raddr  = mem.raddr;
  assign dc.raddr  = mem.raddr;
  assign ic.rdata  = mem.rdata;
  assign dc.rdata  = mem.rdata;

  assign push = i_acc | d_rd_acc;
  assign pop  = ret_beat & (rbeat == BEAT_LAST);

  assign unused_ok = ^{ic.write, ic.wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB;
      prio   <= ID_I;
      wbeat  <= '0;
      rbeat  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (d_wr_acc) begin
        if (wbeat == BEAT_LAST) begin
          state <= ARB;
          wbeat <= '0;
        end else begin
          state <= WBURST;
          wbeat <= wbeat + BW'(1);
        end
      end
      if (state == ARB) begin
        if (i_acc)                      prio <= ID_D;
        else if (d_rd_acc || d_wr_acc)  prio <= ID_I;
      end
      if (ret_beat) rbeat <= (rbeat == BEAT_LAST) ? '0 : rbeat + BW'(1);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= d_rd_acc;
  end

  a_rvalid_needs_read: assert property (@(posedge clk) disable iff (rst) !(mem.rvalid && fifo_empty));
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the instruction-cache and data-cache miss FSMs, between them and the single shared DRAM burst port.
- Arbitrates line-read requests and 4-beat write-back bursts from the two caches onto that port.
- Tracks outstanding reads in issue order and steers each 64-bit return beat back to the cache that requested it.
- Each cache sees a private port with the same ready/read/write/rvalid semantics as the DRAM port.

Parameters:
- MAX_OUTSTANDING, 4, depth of the in-order requester-ID FIFO (maximum reads in flight).
- BEATS, 4, beats per cache line (each beat 64 bits; a line is 256 bits).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_addr  in  32  icache line address (low 5 bits zero)
- i_read  in  1  icache read request; single cycle, valid only when i_ready
- i_ready  out  1  icache request may issue this cycle
- i_raddr  out  32  return line address (copy of mem_raddr)
- i_rdata  out  64  return beat (copy of mem_rdata)
- i_rvalid  out  1  return beat belongs to icache
- d_addr  in  32  dcache line address
- d_read  in  1  dcache read request
- d_write  in  1  dcache write beat; one per cycle, BEATS beats per line
- d_wdata  in  64  dcache write beat data
- d_ready  out  1  dcache request/beat may issue this cycle
- d_raddr  out  32  return line address
- d_rdata  out  64  return beat
- d_rvalid  out  1  return beat belongs to dcache
- mem_addr  out  32  DRAM request address
- mem_read  out  1  DRAM read request
- mem_write  out  1  DRAM write beat
- mem_wdata  out  64  DRAM write data
- mem_ready  in  1  DRAM accepts request/beat this cycle
- mem_raddr  in  32  DRAM return line address
- mem_rdata  in  64  DRAM return beat
- mem_rvalid  in  1  DRAM return beat valid; BEATS beats per read, in request order, gaps allowed

Behaviour:
- Reset: i_ready=0, d_ready=0, mem_read=0, mem_write=0, i_rvalid=0, d_rvalid=0. FSM to ARB, priority pointer to icache, ID FIFO empty, beat counters 0.
- FSM states:
  - ARB: neither cache owns the port.
  - WBURST: dcache owns the port for the remainder of a write burst.
- Request path is combinational: mem_addr, mem_read, mem_write and mem_wdata are driven from the granted client in the same cycle. No added request latency.
- ARB grant rules:
  - i_ready = mem_ready && !fifo_full && (no d request || priority==I).
  - d_ready = mem_ready && (d_write || !fifo_full) && (no i request || priority==D).
  - "No request" means the client's read/write inputs are low. When idle, both readies may be high at once (the caches sample ready before asserting a request).
  - On conflict, the granted client wins; priority flips to the other client after each accepted request.
- Write bursts:
  - The first accepted d_write beat moves ARB -> WBURST with wbeat=1.
  - In WBURST: i_ready=0 and d_ready=mem_ready; each accepted beat increments wbeat.
  - Acceptance of beat BEATS-1 returns the FSM to ARB.
  - Write beats never touch the ID FIFO.
- Reads:
  - An accepted read pushes its requester ID (0=I, 1=D) onto the FIFO in the same cycle.
  - fifo_full blocks new reads only; write bursts still proceed.
- Return path:
  - i_raddr/d_raddr and i_rdata/d_rdata are wired to mem_raddr/mem_rdata.
  - x_rvalid = mem_rvalid && FIFO head == x. Combinational, zero latency.
  - rbeat counts returned beats. On beat BEATS-1 the FIFO pops and rbeat wraps to 0.
  - A simultaneous push and pop in one cycle is legal and leaves the count unchanged.
- mem_rvalid with an empty FIFO is a protocol error: no rvalid is forwarded and an assertion fires.
- Reset mid-burst or mid-read flushes all state; the DRAM model is reset in the same cycle.
- Pointers wrap modulo MAX_OUTSTANDING. The count field is one bit wider than the pointers so full and empty are distinguishable.

Test Plan:
- Lone icache read of 0x0000_1000 with mem_ready=1 -> mem_read=1 and mem_addr=0x1000 the same cycle. Four mem_rvalid beats -> i_rvalid=1 on all 4, d_rvalid=0. FIFO empty afterwards.
- i_read and d_read in the same cycle after reset -> icache granted first, dcache granted the next cycle. Returns route I then D.
- Dcache write-back to 0x2000 with data 0xA..0xD, with an icache read arriving on beat 1 -> 4 consecutive mem_write beats, i_ready=0 throughout. Icache issues the cycle after beat 3.
- mem_ready toggling 1,0,1,0 during a write burst -> each beat goes out only when ready=1; the burst completes with exactly 4 beats in order.
- Issue 4 reads with no returns -> i_ready=d_ready=0 for reads while the FIFO is full; a d_write still proceeds. The first return beat reopens issue only after its 4th beat pops the FIFO.
- Assert rst after 2 of 4 return beats -> all outputs return to 0 next cycle, FIFO empty. A new read then routes correctly.
